memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Parallel-domain stage directly downstream of the two caches' memory_request/memory_request_ready outputs.
- Queues each cache's 25-bit memory requests and arbitrates them round-robin onto one shared memory port.
- Routes each 16-bit read response back to the cache that issued the read.
- The serial input_collector/output_emitter pair for the shared port wraps this block at top level.

Parameters:
- FIFO_DEPTH, 4, entries per requester queue; power of two, minimum 2.
- TIMEOUT_CYCLES, 64, WAIT_RESP cycle limit; used only when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- clock input 1: single clock; all state updates on its rising edge.
- reset input 1: synchronous, active-high.
- request_0 input 25: cache 0 request. [24]=write, [23:8]=address, [7:0]=write data.
- request_ready_0 input 1: one-cycle strobe; request_0 valid this cycle.
- request_1 input 25: cache 1 request, same format as request_0.
- request_ready_1 input 1: one-cycle strobe; request_1 valid this cycle.
- response_0 output 16: read data returned to cache 0.
- response_ready_0 output 1: one-cycle strobe; response_0 valid.
- response_1 output 16: read data returned to cache 1.
- response_ready_1 output 1: one-cycle strobe; response_1 valid.
- mem_request output 25: granted request to the shared memory port.
- mem_request_ready output 1: one-cycle strobe; mem_request valid.
- mem_response input 16: read data from memory.
- mem_response_ready input 1: one-cycle strobe; mem_response valid.
- overflow output 2: sticky per-port drop flags; bit n = port n.
- timeout_error output 1: one-cycle pulse when a read times out.

Behaviour:
- Reset values:
  - All outputs 0.
  - Both FIFOs emptied; FSM in IDLE.
  - last_grant=1, so port 0 wins the first contention.
  - overflow=2'b00.
- Enqueue:
  - request_ready_n high at an edge pushes request_n into FIFO n.
  - If FIFO n is full and not popped that cycle, the request is dropped and overflow[n] sets.
  - overflow[n] clears only on reset.
- Push and pop on the same FIFO in the same cycle are both legal. When full, that pair is accepted and the count is unchanged.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - No FIFO non-empty: stay in IDLE.
  - Exactly one FIFO non-empty: grant that port.
  - Both FIFOs non-empty: grant the port != last_grant.
  - On a grant: latch grant_id, update last_grant, go to ISSUE.
- ISSUE (exactly one cycle):
  - Drive mem_request = head of FIFO grant_id and mem_request_ready=1.
  - Pop that FIFO.
  - Write (bit 24=1): next state IDLE; no response is returned.
  - Read (bit 24=0): next state WAIT_RESP.
- WAIT_RESP:
  - On the edge that sees mem_response_ready=1, register mem_response onto response_<grant_id>.
  - Pulse response_ready_<grant_id> for the following cycle; go to IDLE.
- mem_response_ready in IDLE or ISSUE is ignored.
- response_n data holds its value until the next response to port n.
- At most one transaction is outstanding.
- Latency:
  - request_ready edge N → mem_request_ready high in the cycle after edge N+2 (empty FIFO, FSM idle).
  - mem_response_ready edge → response_ready one cycle later.
- mem_request is 0 whenever mem_request_ready=0.
- Reset mid-operation: the outstanding read is abandoned, and a late mem_response_ready arriving in IDLE is ignored.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on entry to WAIT_RESP.
  - On reaching TIMEOUT_CYCLES-1 without mem_response_ready: response_<grant_id>=16'hFFFF with response_ready pulsed, timeout_error pulsed one cycle, FSM returns to IDLE.
  - A response arriving on the same edge as the timeout wins; no error.
- Undefined: no counter; timeout_error is tied 0; WAIT_RESP waits indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - REQ_WIDTH=25, RESP_WIDTH=16.
  - Field constants: REQ_WRITE_BIT=24, REQ_ADDR_MSB=23, REQ_ADDR_LSB=8, REQ_DATA_MSB=7.
  - State encoding for IDLE/ISSUE/WAIT_RESP.
  - TIMEOUT_DATA=16'hFFFF.
- Sub-module req_fifo:
  - Synchronous FIFO parameterised by width and depth.
  - push/pop/full/empty/head signals.
  - Instantiated twice.

Test Plan:
- Single read: request_0=25'h0_1234_00 (read @0x1234) strobed; mem_response=16'hBEEF strobed 5 cycles after mem_request_ready → mem_request=25'h0_1234_00 two cycles after the strobe; response_0=16'hBEEF with response_ready_0 one cycle later; response_ready_1 stays 0.
- Write: request_1=25'h1_00A0_5C → mem_request=25'h1_00A0_5C issued; FSM back to IDLE next cycle; no response_ready on either port.
- Contention: both ports strobe reads in the same cycle, twice → issue order 0,1,0,1; each response routed to the matching port.
- Overflow: 5 back-to-back reads on port 0 while a read stays outstanding (FIFO_DEPTH=4) → fifth dropped; overflow=2'b01; the four queued entries issue in order after the response.
- Reset mid-read: assert reset during WAIT_RESP, then strobe mem_response_ready → no response_ready; all outputs 0; subsequent request served normally.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: read with no memory response → after 8 WAIT_RESP cycles response_0=16'hFFFF, response_ready_0=1, timeout_error=1 for one cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants, request field positions and FSM encoding for memory_arbiter.
package mem_arb_pkg;

    localparam int REQ_WIDTH     = 25;
    localparam int RESP_WIDTH    = 16;

    localparam int REQ_WRITE_BIT = 24;
    localparam int REQ_ADDR_MSB  = 23;
    localparam int REQ_ADDR_LSB  = 8;
    localparam int REQ_DATA_MSB  = 7;

    localparam logic [RESP_WIDTH-1:0] TIMEOUT_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } arb_state_t;

    function automatic logic req_is_write(input logic [REQ_WIDTH-1:0] req);
        return req[REQ_WRITE_BIT];
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Synchronous FIFO with a registered count; push while full is accepted only
// when a pop happens on the same edge.
module req_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter onto one memory port with read-response routing.
// Optional WAIT_RESP timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REQ_WIDTH-1:0]  request_0,
    input  logic                  request_ready_0,
    input  logic [REQ_WIDTH-1:0]  request_1,
    input  logic                  request_ready_1,
    output logic [RESP_WIDTH-1:0] response_0,
    output logic                  response_ready_0,
    output logic [RESP_WIDTH-1:0] response_1,
    output logic                  response_ready_1,
    output logic [REQ_WIDTH-1:0]  mem_request,
    output logic                  mem_request_ready,
    input  logic [RESP_WIDTH-1:0] mem_response,
    input  logic                  mem_response_ready,
    output logic [1:0]            overflow,
    output logic                  timeout_error,
    output logic [1:0]            o_dbg_state
);

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic                   r_grant_id;
    logic                   r_last_grant;
    logic                   w_grant;
    logic                   w_grant_take;
    logic                   w_issue;
    logic                   w_resp_load;
    logic [RESP_WIDTH-1:0]  w_resp_data;
    logic                   w_timeout;

    logic [REQ_WIDTH-1:0]   w_head_0;
    logic [REQ_WIDTH-1:0]   w_head_1;
    logic [REQ_WIDTH-1:0]   w_head;
    logic                   w_full_0;
    logic                   w_full_1;
    logic                   w_empty_0;
    logic                   w_empty_1;
    logic                   w_pop_0;
    logic                   w_pop_1;
    logic                   w_drop_0;
    logic                   w_drop_1;

    logic [REQ_WIDTH-1:0]   r_mem_request;
    logic                   r_mem_request_ready;
    logic [RESP_WIDTH-1:0]  r_response_0;
    logic [RESP_WIDTH-1:0]  r_response_1;
    logic                   r_response_ready_0;
    logic                   r_response_ready_1;
    logic [1:0]             r_overflow;
    logic                   r_timeout_error;

    req_fifo #(.WIDTH(REQ_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_0 (
        .i_clk   (clock),
        .i_reset (reset),
        .i_push  (request_ready_0),
        .i_data  (request_0),
        .i_pop   (w_pop_0),
        .o_head  (w_head_0),
        .o_full  (w_full_0),
        .o_empty (w_empty_0)
    );

    req_fifo #(.WIDTH(REQ_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
        .i_clk   (clock),
        .i_reset (reset),
        .i_push  (request_ready_1),
        .i_data  (request_1),
        .i_pop   (w_pop_1),
        .o_head  (w_head_1),
        .o_full  (w_full_1),
        .o_empty (w_empty_1)
    );

    assign w_head   = r_grant_id ? w_head_1 : w_head_0;
    assign w_drop_0 = request_ready_0 && w_full_0 && !w_pop_0;
    assign w_drop_1 = request_ready_1 && w_full_1 && !w_pop_1;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_timer;

    // Held at zero outside WAIT_RESP so every wait starts counting from 0.
    always_ff @(posedge clock) begin
        if (reset || (r_state != ST_WAIT_RESP)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = r_grant_id;
        w_grant_take = 1'b0;
        w_pop_0      = 1'b0;
        w_pop_1      = 1'b0;
        w_issue      = 1'b0;
        w_resp_load  = 1'b0;
        w_resp_data  = mem_response;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty_0 || !w_empty_1) begin
                    w_grant_take = 1'b1;
                    // Under contention the port that did not win last time goes next.
                    w_grant      = (!w_empty_0 && !w_empty_1) ? !r_last_grant : w_empty_0;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue      = 1'b1;
                w_pop_0      = !r_grant_id;
                w_pop_1      = r_grant_id;
                w_state_next = req_is_write(w_head) ? ST_IDLE : ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (mem_response_ready) begin
                    w_resp_load  = 1'b1;
                    w_state_next = ST_IDLE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (r_timer == TIMEOUT_LAST) begin
                    w_resp_load  = 1'b1;
                    w_resp_data  = TIMEOUT_DATA;
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
`endif
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant_id          <= 1'b0;
            r_last_grant        <= 1'b1;
            r_mem_request       <= '0;
            r_mem_request_ready <= 1'b0;
            r_response_0        <= '0;
            r_response_1        <= '0;
            r_response_ready_0  <= 1'b0;
            r_response_ready_1  <= 1'b0;
            r_overflow          <= 2'b00;
            r_timeout_error     <= 1'b0;
        end else begin
            if (w_grant_take) begin
                r_grant_id   <= w_grant;
                r_last_grant <= w_grant;
            end
            r_mem_request_ready <= w_issue;
            r_mem_request       <= w_issue ? w_head : '0;
            r_response_ready_0  <= w_resp_load && !r_grant_id;
            r_response_ready_1  <= w_resp_load && r_grant_id;
            if (w_resp_load && !r_grant_id) begin
                r_response_0 <= w_resp_data;
            end
            if (w_resp_load && r_grant_id) begin
                r_response_1 <= w_resp_data;
            end
            r_overflow      <= r_overflow | {w_drop_1, w_drop_0};
            r_timeout_error <= w_timeout;
        end
    end

    assign mem_request       = r_mem_request;
    assign mem_request_ready = r_mem_request_ready;
    assign response_0        = r_response_0;
    assign response_1        = r_response_1;
    assign response_ready_0  = r_response_ready_0;
    assign response_ready_1  = r_response_ready_1;
    assign overflow          = r_overflow;
    assign timeout_error     = r_timeout_error;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: issue order and response routing are
// checked against expected queues; define MEM_ARB_TIMEOUT_EN to add the timeout test.
module tb_memory_arbiter;
    import mem_arb_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [REQ_WIDTH-1:0]  request_0, request_1;
    logic                  request_ready_0, request_ready_1;
    logic [RESP_WIDTH-1:0] response_0, response_1;
    logic                  response_ready_0, response_ready_1;
    logic [REQ_WIDTH-1:0]  mem_request;
    logic                  mem_request_ready;
    logic [RESP_WIDTH-1:0] mem_response;
    logic                  mem_response_ready;
    logic [1:0]            overflow;
    logic                  timeout_error;
    logic [1:0]            o_dbg_state;

    int total = 0;
    int bad   = 0;

    logic [REQ_WIDTH-1:0] exp_q[$];
    logic [16:0]          exp_resp_q[$];
    logic                 saw_issue;
    logic [REQ_WIDTH-1:0] last_req;

    always #5 clock = ~clock;

    memory_arbiter #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clock              (clock),
        .reset              (reset),
        .request_0          (request_0),
        .request_ready_0    (request_ready_0),
        .request_1          (request_1),
        .request_ready_1    (request_ready_1),
        .response_0         (response_0),
        .response_ready_0   (response_ready_0),
        .response_1         (response_1),
        .response_ready_1   (response_ready_1),
        .mem_request        (mem_request),
        .mem_request_ready  (mem_request_ready),
        .mem_response       (mem_response),
        .mem_response_ready (mem_response_ready),
        .overflow           (overflow),
        .timeout_error      (timeout_error),
        .o_dbg_state        (o_dbg_state)
    );

    function automatic logic [REQ_WIDTH-1:0] mk_req(input logic wr, input logic [15:0] addr,
                                                    input logic [7:0] data);
        logic [REQ_WIDTH-1:0] r;
        r = '0;
        r[REQ_WRITE_BIT] = wr;
        r[REQ_ADDR_MSB:REQ_ADDR_LSB] = addr;
        r[REQ_DATA_MSB:0] = data;
        return r;
    endfunction

    // Memory model: read data is a fixed scramble of the address.
    function automatic logic [15:0] mem_data(input logic [15:0] addr);
        return addr ^ 16'hACDB;
    endfunction

    // Advance to the next falling edge and score whatever the DUT produced.
    task automatic tick();
        logic [REQ_WIDTH-1:0] e;
        logic [16:0]          er;
        @(negedge clock);
        saw_issue = mem_request_ready;
        if (mem_request_ready) begin
            last_req = mem_request;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected: got %h, required no issue", mem_request);
            end else begin
                e = exp_q.pop_front();
                if (mem_request !== e) begin
                    bad++;
                    $display("FAIL issue_value: got %h, required %h", mem_request, e);
                end
            end
        end else if (mem_request !== '0) begin
            total++;
            bad++;
            $display("FAIL idle_request: got %h, required 0", mem_request);
        end
        if (response_ready_0 === 1'b1 || response_ready_1 === 1'b1) begin
            total++;
            if (exp_resp_q.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: rr0=%b rr1=%b, required none", response_ready_0,
                         response_ready_1);
            end else begin
                er = exp_resp_q.pop_front();
                if ((er[16] ? {response_ready_1, response_ready_0} : {response_ready_0, response_ready_1})
                        !== 2'b10 || (er[16] ? response_1 : response_0) !== er[15:0]) begin
                    bad++;
                    $display("FAIL resp_route: rr0=%b r0=%h rr1=%b r1=%h, required port %0d data %h",
                             response_ready_0, response_0, response_ready_1, response_1, er[16], er[15:0]);
                end
            end
        end
    endtask

    task automatic wait_issue();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (saw_issue) return;
        end
        total++;
        bad++;
        $display("FAIL wait_issue: no mem_request_ready within 40 cycles, required one");
    endtask

    task automatic send_response(input int delay, input logic port, input logic [15:0] addr);
        repeat (delay) tick();
        mem_response       = mem_data(addr);
        mem_response_ready = 1'b1;
        exp_resp_q.push_back({port, mem_data(addr)});
        tick();
        mem_response_ready = 1'b0;
        mem_response       = '0;
        total++;
        if (exp_resp_q.size() != 0) begin
            bad++;
            $display("FAIL resp_missing: %0d pending, required 0", exp_resp_q.size());
            exp_resp_q.delete();
        end
    endtask

    task automatic push_req(input logic port, input logic [REQ_WIDTH-1:0] req);
        if (port) begin
            request_1 = req; request_ready_1 = 1'b1;
        end else begin
            request_0 = req; request_ready_0 = 1'b1;
        end
    endtask

    task automatic clear_req();
        request_0 = '0; request_ready_0 = 1'b0;
        request_1 = '0; request_ready_1 = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({response_0, response_ready_0, response_1, response_ready_1, mem_request,
             mem_request_ready, overflow, timeout_error} !== '0 || o_dbg_state !== 2'(ST_IDLE)) begin
            bad++;
            $display("FAIL %s: r0=%h rr0=%b r1=%h rr1=%b mreq=%h mrr=%b ovf=%b to=%b st=%0d, required all 0",
                     name, response_0, response_ready_0, response_1, response_ready_1, mem_request,
                     mem_request_ready, overflow, timeout_error, o_dbg_state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_req();
        mem_response = '0; mem_response_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_all_zero("reset_state");
    endtask

    task automatic test_single_read();
        logic [REQ_WIDTH-1:0] req;
        req = mk_req(1'b0, 16'h1234, 8'h00);
        exp_q.push_back(req);
        push_req(1'b0, req);
        tick();
        clear_req();
        tick();
        total++;
        if (mem_request_ready !== 1'b0) begin
            bad++;
            $display("FAIL read_latency_early: mrr=%b, required 0", mem_request_ready);
        end
        tick();
        total++;
        if (mem_request_ready !== 1'b1 || mem_request !== 25'h0_1234_00) begin
            bad++;
            $display("FAIL read_latency: mrr=%b mreq=%h, required 1 and 0123400", mem_request_ready, mem_request);
        end
        send_response(4, 1'b0, 16'h1234);
        total++;
        if (response_0 !== 16'hBEEF || response_ready_0 !== 1'b1 || response_ready_1 !== 1'b0) begin
            bad++;
            $display("FAIL read_response: r0=%h rr0=%b rr1=%b, required beef 1 0", response_0,
                     response_ready_0, response_ready_1);
        end
        tick();
        total++;
        if (response_ready_0 !== 1'b0 || response_0 !== 16'hBEEF) begin
            bad++;
            $display("FAIL read_hold: rr0=%b r0=%h, required 0 beef", response_ready_0, response_0);
        end
    endtask

    task automatic test_write();
        logic [REQ_WIDTH-1:0] req;
        req = mk_req(1'b1, 16'h00A0, 8'h5C);
        exp_q.push_back(req);
        push_req(1'b1, req);
        tick();
        clear_req();
        wait_issue();
        total++;
        if (o_dbg_state !== 2'(ST_IDLE) || last_req !== 25'h1_00A0_5C) begin
            bad++;
            $display("FAIL write_issue: st=%0d mreq=%h, required IDLE 100a05c", o_dbg_state, last_req);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (response_ready_0 !== 1'b0 || response_ready_1 !== 1'b0) begin
                bad++;
                $display("FAIL write_no_resp: rr0=%b rr1=%b, required 0 0", response_ready_0, response_ready_1);
            end
        end
    endtask

    task automatic test_contention();
        logic [15:0] addrs [4];
        addrs[0] = 16'h0200; addrs[1] = 16'h0300; addrs[2] = 16'h0201; addrs[3] = 16'h0301;
        for (int k = 0; k < 2; k++) begin
            push_req(1'b0, mk_req(1'b0, addrs[2*k], 8'h00));
            push_req(1'b1, mk_req(1'b0, addrs[2*k+1], 8'h00));
            tick();
        end
        clear_req();
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_req(1'b0, addrs[i], 8'h00));
        for (int i = 0; i < 4; i++) begin
            wait_issue();
            send_response(2, 1'(i % 2), addrs[i]);
        end
    endtask

    task automatic test_overflow();
        logic [REQ_WIDTH-1:0] req;
        req = mk_req(1'b0, 16'h0400, 8'h00);
        exp_q.push_back(req);
        push_req(1'b0, req);
        tick();
        clear_req();
        wait_issue();
        for (int k = 0; k < 5; k++) begin
            req = mk_req(1'b0, 16'h0410 + 16'(k), 8'h00);
            if (k < 4) exp_q.push_back(req);
            push_req(1'b0, req);
            tick();
        end
        clear_req();
        total++;
        if (overflow !== 2'b01) begin
            bad++;
            $display("FAIL overflow_set: got %b, required 01", overflow);
        end
        send_response(1, 1'b0, 16'h0400);
        for (int k = 0; k < 4; k++) begin
            wait_issue();
            send_response(1, 1'b0, 16'h0410 + 16'(k));
        end
        total++;
        if (overflow !== 2'b01 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL overflow_drain: ovf=%b pending=%0d, required 01 0", overflow, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_read();
        logic [REQ_WIDTH-1:0] req;
        req = mk_req(1'b0, 16'h0ABC, 8'h00);
        exp_q.push_back(req);
        push_req(1'b0, req);
        tick();
        clear_req();
        wait_issue();
        tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check_all_zero("reset_mid_read");
        mem_response = 16'h1111; mem_response_ready = 1'b1;
        tick();
        mem_response = '0; mem_response_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (response_ready_0 !== 1'b0 || response_ready_1 !== 1'b0) begin
                bad++;
                $display("FAIL late_resp_ignored: rr0=%b rr1=%b, required 0 0", response_ready_0, response_ready_1);
            end
        end
        req = mk_req(1'b0, 16'h0042, 8'h00);
        exp_q.push_back(req);
        push_req(1'b1, req);
        tick();
        clear_req();
        wait_issue();
        send_response(2, 1'b1, 16'h0042);
        total++;
        if (response_1 !== mem_data(16'h0042)) begin
            bad++;
            $display("FAIL after_reset_read: r1=%h, required %h", response_1, mem_data(16'h0042));
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [REQ_WIDTH-1:0] req;
        req = mk_req(1'b0, 16'h0777, 8'h00);
        exp_q.push_back(req);
        push_req(1'b0, req);
        tick();
        clear_req();
        wait_issue();
        repeat (7) tick();
        total++;
        if (timeout_error !== 1'b0 || response_ready_0 !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: to=%b rr0=%b, required 0 0", timeout_error, response_ready_0);
        end
        exp_resp_q.push_back({1'b0, 16'hFFFF});
        tick();
        total++;
        if (timeout_error !== 1'b1 || response_ready_0 !== 1'b1 || response_0 !== 16'hFFFF) begin
            bad++;
            $display("FAIL timeout_fire: to=%b rr0=%b r0=%h, required 1 1 ffff", timeout_error,
                     response_ready_0, response_0);
        end
        tick();
        total++;
        if (timeout_error !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: to=%b, required 0", timeout_error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_overflow();
        test_reset_mid_read();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) tick();
        total++;
        if (exp_q.size() != 0 || exp_resp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: req=%0d resp=%0d pending, required 0 0", exp_q.size(),
                     exp_resp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
